// File: rtl/load_store_unit.sv
// Load/store unit between execute stage and a single-port data memory with one-cycle read latency.
// Optional LSU_MISALIGN_SPLIT_EN splits word/halfword accesses that cross a word boundary into two accesses.
module load_store_unit #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] ROM_BASE  = 32'h0010_0000,
    parameter int          ROM_WORDS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqUnsigned,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWdata,
    output logic        rspValid,
    output logic [31:0] rspData,
    output logic        rspError,
    output logic        memReadEnable,
    output logic        memWriteEnable,
    output logic [3:0]  memReadByteSelect,
    output logic [3:0]  memWriteByteSelect,
    output logic [31:0] memAddress,
    output logic [31:0] memDataOut,
    input  logic [31:0] memDataIn
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_ISSUE2 = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    localparam logic [30:0] MEM_LIMIT = MEM_WORDS[30:0];
    localparam logic [29:0] ROM_W0    = ROM_BASE[31:2];
    localparam logic [30:0] ROM_WEND  = {1'b0, ROM_W0} + ROM_WORDS[30:0];

    state_t      r_state;
    state_t      w_next;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_off;
    logic [29:0] r_word;
    logic [31:0] r_wdata_rot;
    logic [7:0]  r_lanes;
    logic        r_split;
    logic        r_err;
    logic [31:0] r_lo;
    logic [31:0] r_rsp_data;

    logic [3:0]  w_mask;
    logic [7:0]  w_lanes;
    logic        w_split;
    logic        w_misalign;
    logic        w_wrap;
    logic        w_err;
    logic [29:0] w_word;
    logic [29:0] w_word_hi;
    logic [63:0] w_cat;
    logic [63:0] w_shift;
    logic [31:0] w_ld;
    logic        w_accept;
    logic        w_access;

    function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] o);
        case (o)
            2'd0:    rotl_bytes = d;
            2'd1:    rotl_bytes = {d[23:0], d[31:24]};
            2'd2:    rotl_bytes = {d[15:0], d[31:16]};
            2'd3:    rotl_bytes = {d[7:0],  d[31:8]};
            default: rotl_bytes = d;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz, input logic uns);
        case (sz)
            2'b00:   extend = uns ? {24'h0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
            2'b01:   extend = uns ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    // ROM words are outside data memory: readable, never writable.
    function automatic logic word_bad(input logic [29:0] w, input logic wr);
        logic in_mem;
        logic in_rom;
        in_mem = ({1'b0, w} < MEM_LIMIT);
        in_rom = (w >= ROM_W0) && ({1'b0, w} < ROM_WEND);
        word_bad = wr ? (!in_mem || in_rom) : (!in_mem && !in_rom);
    endfunction

    assign w_word    = reqAddr[31:2];
    assign w_word_hi = w_word + 30'd1;
    assign w_accept  = reqValid && (r_state == S_IDLE);

    // Request decode and error classification at acceptance.
    always_comb begin
        case (reqSize)
            2'b00:   w_mask = 4'b0001;
            2'b01:   w_mask = 4'b0011;
            2'b10:   w_mask = 4'b1111;
            default: w_mask = 4'b0000;
        endcase
        w_lanes = {4'b0000, w_mask} << reqAddr[1:0];
`ifdef LSU_MISALIGN_SPLIT_EN
        w_split    = ((reqSize == 2'b01) && (reqAddr[1:0] == 2'd3)) ||
                     ((reqSize == 2'b10) && (reqAddr[1:0] != 2'd0));
        w_misalign = 1'b0;
`else
        w_split    = 1'b0;
        w_misalign = ((reqSize == 2'b01) && reqAddr[0]) ||
                     ((reqSize == 2'b10) && (reqAddr[1:0] != 2'd0));
`endif
        w_wrap = w_split && (w_word == 30'h3FFF_FFFF);
        w_err  = (reqSize == 2'b11) || w_misalign || w_wrap ||
                 word_bad(w_word, reqWrite) ||
                 (w_split && word_bad(w_word_hi, reqWrite));
    end

    // Load data: high word arrives on memDataIn while the low word sits in r_lo.
    always_comb begin
        if (r_split) begin
            w_cat = {memDataIn, r_lo};
        end else begin
            w_cat = {32'h0, memDataIn};
        end
        w_shift = w_cat >> {r_off, 3'b000};
        w_ld    = extend(w_shift[31:0], r_size, r_unsigned);
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (reqValid) begin
                    w_next = w_err ? S_RESP : S_ISSUE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (r_split) begin
                    w_next = S_ISSUE2;
                end else if (r_write) begin
                    w_next = S_RESP;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_ISSUE2: w_next = r_write ? S_RESP : S_WAIT;
            S_WAIT:   w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State and request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_off       <= 2'b00;
            r_word      <= 30'h0;
            r_wdata_rot <= 32'h0;
            r_lanes     <= 8'h00;
            r_split     <= 1'b0;
            r_err       <= 1'b0;
            r_lo        <= 32'h0;
            r_rsp_data  <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write     <= reqWrite;
                r_size      <= reqSize;
                r_unsigned  <= reqUnsigned;
                r_off       <= reqAddr[1:0];
                r_word      <= w_word;
                r_wdata_rot <= rotl_bytes(reqWdata, reqAddr[1:0]);
                r_lanes     <= w_lanes;
                r_split     <= w_split && !w_err;
                r_err       <= w_err;
                r_rsp_data  <= 32'h0;
            end
            if ((r_state == S_ISSUE2) && !r_write) begin
                r_lo <= memDataIn;
            end
            if (r_state == S_WAIT) begin
                r_rsp_data <= w_ld;
            end
        end
    end

    assign reqReady = (r_state == S_IDLE);
    assign rspValid = (r_state == S_RESP);
    assign rspError = (r_state == S_RESP) && r_err;
    assign rspData  = r_rsp_data;
    assign w_access = (r_state == S_ISSUE) || (r_state == S_ISSUE2);

    // Memory strobes decoded from registered state only.
    always_comb begin
        memReadEnable      = w_access && !r_write;
        memWriteEnable     = w_access && r_write;
        memReadByteSelect  = 4'b0000;
        memWriteByteSelect = 4'b0000;
        memAddress         = 32'h0;
        memDataOut         = 32'h0;
        case (r_state)
            S_ISSUE: begin
                memAddress = {r_word, 2'b00};
                if (r_write) begin
                    memWriteByteSelect = r_lanes[3:0];
                    memDataOut         = r_wdata_rot;
                end else begin
                    memReadByteSelect  = 4'b1111;
                end
            end
            S_ISSUE2: begin
                memAddress = {r_word + 30'd1, 2'b00};
                if (r_write) begin
                    memWriteByteSelect = r_lanes[7:4];
                    memDataOut         = r_wdata_rot;
                end else begin
                    memReadByteSelect  = 4'b1111;
                end
            end
            default: begin
                memAddress = 32'h0;
            end
        endcase
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side load/store unit between the core's execute stage and the single-port data memory. Takes one byte/halfword/word request at a time, drives the memory's read/write strobes, byte selects, word address and write data, and captures the memory's one-cycle registered read data. Loads are lane-extracted and sign- or zero-extended. Stores get lane-aligned byte enables. Out-of-range and malformed requests are reported with an error flag and never reach the memory.

## Interface
Parameters:
- MEM_WORDS, 1024: number of 32-bit words in data memory; word index `addr>>2 >= MEM_WORDS` is out of range.
- ROM_BASE, 32'h0010_0000: byte base of the read-only constant window.
- ROM_WORDS, 2: word count of the ROM window. Loads are legal there; stores there are errors.

Ports:
- Clock and reset (already decided): one clock, `clk`; reset `reset` is synchronous and active-high.
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- reqValid  in  1  request strobe.
- reqReady  out  1  high only in IDLE; a request is accepted when reqValid & reqReady.
- reqWrite  in  1  1 = store, 0 = load.
- reqSize  in  2  00 byte, 01 half, 10 word, 11 reserved.
- reqUnsigned  in  1  load zero-extends when 1, sign-extends when 0.
- reqAddr  in  32  byte address.
- reqWdata  in  32  store data, right-justified.
- rspValid  out  1  one-cycle completion pulse; no backpressure.
- rspData  out  32  extended load data; 0 for stores and errors.
- rspError  out  1  qualifies rspValid.
- memReadEnable  out  1  to memory readEnable.
- memWriteEnable  out  1  to memory writeEnable.
- memReadByteSelect  out  4  4'b1111 while reading, else 0.
- memWriteByteSelect  out  4  lane enables.
- memAddress  out  32  word-aligned (bits [1:0] = 0).
- memDataOut  out  32  to memory dataIn.
- memDataIn  in  32  from memory dataOut; valid the cycle after memReadEnable.

## Operation
- States: IDLE, ISSUE, ISSUE2, WAIT, RESP. On acceptance the request is registered, with offset o = addr[1:0] and word W = addr>>2.
- Errors are checked in IDLE at acceptance, before any strobe. Error conditions:
  - reqSize = 11.
  - Misaligned access (see Configuration).
  - Any touched word is out of range and not in the ROM window (loads).
  - Any touched word is out of range or in the ROM window (stores).
- On error: IDLE→RESP with rspError = 1 and rspData = 0. No memory strobe is issued.
- Store, single word: ISSUE drives memWriteEnable, memAddress = W<<2, memWriteByteSelect = mask<<o, and memDataOut = reqWdata rotated left by 8·o. mask is 0001, 0011 or 1111 by size. Then RESP.
- Load, single word: ISSUE drives memReadEnable, then WAIT. In WAIT the memDataIn bytes at lane o are extracted and extended into rspData. Then RESP.
- RESP asserts rspValid for exactly one cycle, then IDLE.
- Signed extension replicates the top bit of the selected byte or half.
- Strobes are decoded from registered state only; no combinational path from req* to mem*.

## Timing
- Acceptance cycle is n.
- Aligned store: write strobe in cycle n+1; rspValid in cycle n+2.
- Aligned load: read strobe n+1, data on memDataIn n+2, rspValid n+3.
- Split store: strobes n+1 (W) and n+2 (W+1); rspValid n+3.
- Split load: strobes n+1 and n+2; data n+2 and n+3; rspValid n+4.
- Error: rspValid in cycle n+1.
- reqReady deasserts from n+1 until the cycle after the rspValid pulse. Back-to-back throughput is one aligned load per 4 cycles.
- Reset values:
  - State IDLE, reqReady 1.
  - rspValid, rspError, memReadEnable, memWriteEnable 0.
  - rspData, memAddress, memDataOut 0; both byte selects 0.
- Reset mid-operation: IDLE on the next edge, all strobes low, no rspValid. A split store may already have written its first word; this is not rolled back.
- W+1 wrap: W = 2^30−1 makes W+1 wrap to 0. This is flagged as an error, not wrapped.

## Configuration
- LSU_MISALIGN_SPLIT_EN defined:
  - Halfword at o = 1 is a single access (lanes 1–2).
  - Halfword at o = 3 and word at o ≠ 0 become two accesses. The low part goes to W with lanes o..3. The high part goes to W+1 with the remaining low lanes. Both use the same rotated data.
  - Loads concatenate {word W+1, word W} and shift right by 8·o before extension.
  - ISSUE2 is used only for these split accesses.
- Undefined:
  - Halfword with addr[0] = 1 or word with addr[1:0] ≠ 0 is a misaligned error.
  - ISSUE2 is unreachable.

## Test plan
- Store word 0xA1B2C3D4 to 0x10, then load word 0x10. Required: write strobe with select 1111, address 0x10; load rspData = 0xA1B2C3D4 at n+3 with rspError = 0.
- Memory word 0x0000_80F0 at 0x20. Load byte 0x21 signed → 0xFFFFFF80. Load byte 0x21 unsigned → 0x00000080. Load half 0x20 signed → 0xFFFF80F0.
- Store byte 0x5A to 0x33: memWriteByteSelect = 1000, memDataOut[31:24] = 0x5A.
- Load 0x0010_0004 → not an error; data is forwarded. Store there → rspError = 1 at n+1, no strobe. Load 0x1000 (word 1024) → rspError = 1.
- Word store 0x11223344 at 0x41:
  - With the macro: W = 0x10 gets lanes 1110, then W = 0x11 gets lanes 0001. A subsequent load of 0x41 returns 0x11223344 at n+4.
  - Without the macro: rspError = 1 at n+1.
- Assert reset during WAIT of a load: no rspValid; next cycle reqReady = 1 and all mem strobes low.
